result_store_writer: RTL
========================

# result_store_writer

Downstream stage of the frame-level master controller. It takes one store request per scanned window group: a start pulse with X/Y position and scale index, plus the per-core pass vector from the processor cluster. For every passing window it writes a packed 32-bit detection record to external memory through a write-only Avalon-MM master. An exit request writes a terminating record and parks the block in DONE until reset.

## Interface
Parameters:
- CORES, 4, processors per group; core i evaluates window at start_x+i
- ADDR_W, 32, byte-address width of the write master
- BASE_ADDR, 0, byte address of record 0 (word-aligned)
- MAX_RECORDS, 4096, record slots in the result buffer including the exit slot (>=2)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; one clock, asynchronous, active-low
- start  in  1  store request; accepted only while ready=1
- start_x  in  12  X of core 0's window
- start_y  in  12  Y of the group
- scale  in  7  scale index
- exit  in  1  with start: write the exit record instead of detections
- hits  in  CORES  bit i=1 when core i's window passed all stages
- ready  out  1  IDLE, can accept start
- done  out  1  exit record committed; stays high until reset
- overflow  out  1  sticky; at least one detection was dropped
- record_count  out  16  data records committed since reset
- avm_address  out  ADDR_W  write byte address
- avm_write  out  1  write strobe
- avm_writedata  out  32  record
- avm_waitrequest  in  1  slave stall

## Operation
- Record format: [31] exit flag, [30:24] scale, [23:12] x, [11:0] y.
  - Data record x is (start_x+i) mod 4096.
- States:
  - IDLE: ready=1. On start, latch all inputs and clear core index idx. If exit=1, go to EXIT_WR; otherwise go to SCAN.
  - SCAN: examine latched hits[idx].
    - If the bit is set and slots are free, go to WRITE.
    - If the bit is set and slots are full, set overflow and skip the core.
    - If the bit is clear, skip the core.
    - A skip advances idx. After idx=CORES-1, return to IDLE.
  - WRITE: drive avm_write=1 with the record and the current address.
    - Hold address, data and strobe stable while avm_waitrequest=1.
    - On the cycle avm_waitrequest=0 the write commits: address += 4, record_count++.
    - Then advance idx and go to SCAN, or to IDLE if idx was CORES-1.
  - EXIT_WR: write the exit record, holding under waitrequest as in WRITE. On commit, go to DONE.
  - DONE: done=1, ready=0. start is ignored.
- Capacity rules:
  - Data records are limited to MAX_RECORDS-1. The last slot is always reserved for the exit record, so the exit record is never dropped.
  - Exit record without the config macro: {1, 7'd0, latched start_x, latched start_y}.
- Input hold: hits and the other request inputs are sampled only on the accepting cycle; changes afterwards are ignored.
- Asynchronous reset, including mid-write:
  - Immediately: avm_write=0, ready=0, done=0, overflow=0.
  - Cleared: record_count=0, address=BASE_ADDR, state=IDLE.
  - ready rises on the first clock edge after deassertion.
- Reset values of outputs:
  - ready=0 (asserted from the first clk edge after deassertion), done=0, overflow=0, record_count=0.
  - avm_write=0, avm_address=BASE_ADDR, avm_writedata=0.

## Timing
- start sampled at edge T0 (in IDLE) moves the FSM to SCAN; ready is low from T0.
- Each SCAN cycle examines one core. Each hit adds one WRITE cycle plus one cycle per waitrequest stall.
- With hits=0, ready returns CORES+1 cycles after T0.
- With k hits and no stalls, ready returns CORES+1+k cycles after T0.
- Exit with no stall: avm_write is high in cycle T0+1 and done is high from T0+2.
- start with ready=0 is ignored; there is no queueing. The master must hold start until ready.

## Configuration
- RESULT_STORE_COUNT_EN defined: the exit record's bits [23:0] carry record_count zero-extended, bits [30:24]=0, and bit 31=1.
- Undefined: the exit record carries latched start_x/start_y as above.
- Everything else is identical in both builds.

## Test plan
- Reset, then start with x=10, y=5, scale=3, hits=4'b0101, no stalls: two writes, 0x030_0A_005 at BASE_ADDR and 0x030_0C_005 at BASE_ADDR+4; record_count=2; ready high 7 cycles after accept.
- hits=4'b1111 with waitrequest held for 3 cycles on the first write: address, data and strobe stable through the stall; 4 records committed in order; ready returns after 12 cycles.
- MAX_RECORDS=4, two starts with hits=4'b0011: 3 data records written, the 4th hit dropped, overflow=1. Exit then writes at BASE_ADDR+12 and done=1.
- Exit with start_x=640, start_y=480, macro undefined: record 0x8028_01E0. With RESULT_STORE_COUNT_EN and 5 prior records: 0x8000_0005.
- resetn asserted while avm_write=1 under waitrequest: avm_write drops without waiting for a clock. After release: address=BASE_ADDR, record_count=0, ready=1 on the next edge.
- start pulsed while in SCAN, and later in DONE: no effect; record count and address unchanged.

Source files
------------

// File: rtl/result_store_writer.sv
// result_store_writer: commits one packed detection record per passing window over a
// write-only Avalon-MM master. Define RESULT_STORE_COUNT_EN to carry record_count in the exit record.
module result_store_writer #(
    parameter int                CORES       = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                MAX_RECORDS = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [11:0]       start_x,
    input  logic [11:0]       start_y,
    input  logic [6:0]        scale,
    input  logic              exit,
    input  logic [CORES-1:0]  hits,
    output logic              ready,
    output logic              done,
    output logic              overflow,
    output logic [15:0]       record_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest
);
    localparam int               IDX_W      = (CORES > 1) ? $clog2(CORES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(CORES - 1);
    localparam logic [16:0]      DATA_SLOTS = 17'(MAX_RECORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_EXIT_WR,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [11:0]       x_q, y_q;
    logic [6:0]        scale_q;
    logic [CORES-1:0]  hits_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       count_q;
    logic              ready_q, done_q, overflow_q;

    logic              accept, last, slots_free, take_hit;
    logic [31:0]       data_rec, exit_rec;

    assign accept     = (state == S_IDLE) && ready_q && start;
    assign last       = (idx == LAST_IDX);
    // The final slot is kept for the exit record, so data stops one short of MAX_RECORDS.
    assign slots_free = ({1'b0, count_q} < DATA_SLOTS);
    assign take_hit   = hits_q[idx] && slots_free;
    assign data_rec   = {1'b0, scale_q, x_q + 12'(idx), y_q};

`ifdef RESULT_STORE_COUNT_EN
    assign exit_rec = {1'b1, 7'd0, 8'd0, count_q};
`else
    assign exit_rec = {1'b1, 7'd0, x_q, y_q};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        avm_write     = 1'b0;
        avm_writedata = 32'd0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = exit ? S_EXIT_WR : S_SCAN;
            end
            S_SCAN: begin
                if (take_hit)  state_nxt = S_WRITE;
                else if (last) state_nxt = S_IDLE;
            end
            S_WRITE: begin
                avm_write     = 1'b1;
                avm_writedata = data_rec;
                if (!avm_waitrequest) state_nxt = last ? S_IDLE : S_SCAN;
            end
            S_EXIT_WR: begin
                avm_write     = 1'b1;
                avm_writedata = exit_rec;
                if (!avm_waitrequest) state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ready and done trail the state by one edge so both read low throughout reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= 16'd0;
            addr_q     <= BASE_ADDR;
            idx        <= '0;
            x_q        <= 12'd0;
            y_q        <= 12'd0;
            scale_q    <= 7'd0;
            hits_q     <= '0;
        end else begin
            ready_q <= (state == S_IDLE) && !accept;
            done_q  <= (state == S_DONE);
            if (accept) begin
                x_q     <= start_x;
                y_q     <= start_y;
                scale_q <= scale;
                hits_q  <= hits;
                idx     <= '0;
            end
            case (state)
                S_SCAN: begin
                    if (!take_hit) begin
                        if (hits_q[idx]) overflow_q <= 1'b1;
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        addr_q  <= addr_q + ADDR_W'(4);
                        count_q <= count_q + 16'd1;
                        idx     <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready        = ready_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign record_count = count_q;
    assign avm_address  = addr_q;

endmodule
